spi_master_wrapper: RTL and testbench

SPI_MASTER_WRAPPER -- requirements
Module: spi_master_wrapper

---
 rtl/spi_master_pkg.sv | 26 ++
 rtl/spi_master.sv | 220 ++++++++++++++++++++++
 rtl/spi_master_wrapper.sv | 65 ++++++
 tb/tb_spi_master_wrapper.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master slice.
//   state_t   : transaction FSM states
//   BYTE_W    : width of one SPI transfer (bits)
//   pick_bit  : bit of a byte that goes on the wire next, given the bit order
//   advance   : byte with that bit consumed, zero-filled from the far end
package spi_master_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_PUSH,
    ST_DONE
  } state_t;

  function automatic logic pick_bit(input logic [BYTE_W-1:0] d, input logic msb_first);
    return msb_first ? d[BYTE_W-1] : d[0];
  endfunction

  function automatic logic [BYTE_W-1:0] advance(input logic [BYTE_W-1:0] d, input logic msb_first);
    return msb_first ? {d[BYTE_W-2:0], 1'b0} : {1'b0, d[BYTE_W-1:1]};
  endfunction

endpackage

// File: rtl/spi_master.sv
// SPI master core: byte-stream in, byte-stream out, one SPI byte per TX beat.
// Holds the transaction FSM, TX/RX shift registers and the SCLK divider.
// Ports:
//   i_clk, i_rst              clock; synchronous reset at level RST_LEVEL_G
//   o_sclk, o_mosi, i_miso    SPI bus
//   o_cs                      chip select, active-low
//   i_s_t*/o_s_tready         TX byte stream (AXI-Stream style)
//   o_m_t*/i_m_tready         RX byte stream (AXI-Stream style)
//   i_trigger                 start request, level-sampled in IDLE
//   o_num_bytes               bytes completed in current/last transaction (saturating)
//   o_busy                    high from start until cs is released
module spi_master
  import spi_master_pkg::*;
#(
  parameter int unsigned CLOCK_POLARITY_G = 0,
  parameter int unsigned CLOCK_PHASE_G    = 0,
  parameter int unsigned MSB_FIRST_G      = 1,
  parameter int unsigned RST_LEVEL_G      = 0,
  parameter int unsigned SCLK_HALF_G      = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_sclk,
  output logic              o_mosi,
  input  logic              i_miso,
  output logic              o_cs,
  input  logic [BYTE_W-1:0] i_s_tdata,
  input  logic              i_s_tvalid,
  output logic              o_s_tready,
  input  logic              i_s_tlast,
  output logic [BYTE_W-1:0] o_m_tdata,
  output logic              o_m_tvalid,
  input  logic              i_m_tready,
  output logic              o_m_tlast,
  input  logic              i_trigger,
  output logic [31:0]       o_num_bytes,
  output logic              o_busy
);

  localparam logic        CPOL     = (CLOCK_POLARITY_G != 0);
  localparam logic        CPHA     = (CLOCK_PHASE_G != 0);
  localparam logic        MSBF     = (MSB_FIRST_G != 0);
  localparam logic        RSTL     = (RST_LEVEL_G != 0);
  localparam int unsigned HALF     = (SCLK_HALF_G == 0) ? 32'd1 : SCLK_HALF_G;
  localparam int unsigned DIV_W    = (HALF < 2) ? 1 : $clog2(HALF);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);

  state_t              r_state, w_state_nxt;
  logic [DIV_W-1:0]    r_div, w_div_nxt;
  logic [3:0]          r_edge, w_edge_nxt;
  logic [BYTE_W-1:0]   r_tx, w_tx_nxt;
  logic [BYTE_W-1:0]   r_rx, w_rx_nxt;
  logic                r_last, w_last_nxt;
  logic                r_sclk, w_sclk_nxt;
  logic                r_mosi, w_mosi_nxt;
  logic                r_cs, w_cs_nxt;
  logic                r_s_tready, w_s_tready_nxt;
  logic [BYTE_W-1:0]   r_m_tdata, w_m_tdata_nxt;
  logic                r_m_tvalid, w_m_tvalid_nxt;
  logic                r_m_tlast, w_m_tlast_nxt;
  logic [31:0]         r_num, w_num_nxt;
  logic                r_busy, w_busy_nxt;

  logic                w_hit;
  logic                w_sample;
  logic [BYTE_W-1:0]   w_rx_shift;

  assign w_hit      = (r_div == DIV_LAST);
  // Even edge indices are leading edges (away from idle). CPHA=0 samples on
  // leading edges, CPHA=1 on trailing ones; the other edge kind shifts mosi.
  assign w_sample   = CPHA ? r_edge[0] : ~r_edge[0];
  assign w_rx_shift = MSBF ? {r_rx[BYTE_W-2:0], i_miso} : {i_miso, r_rx[BYTE_W-1:1]};

  always_comb begin
    w_state_nxt    = r_state;
    w_div_nxt      = r_div;
    w_edge_nxt     = r_edge;
    w_tx_nxt       = r_tx;
    w_rx_nxt       = r_rx;
    w_last_nxt     = r_last;
    w_sclk_nxt     = r_sclk;
    w_mosi_nxt     = r_mosi;
    w_cs_nxt       = r_cs;
    w_s_tready_nxt = r_s_tready;
    w_m_tdata_nxt  = r_m_tdata;
    w_m_tvalid_nxt = r_m_tvalid;
    w_m_tlast_nxt  = r_m_tlast;
    w_num_nxt      = r_num;
    w_busy_nxt     = r_busy;

    unique case (r_state)
      ST_IDLE: begin
        if (i_trigger) begin
          w_state_nxt    = ST_FETCH;
          w_cs_nxt       = 1'b0;
          w_busy_nxt     = 1'b1;
          w_num_nxt      = '0;
          w_s_tready_nxt = 1'b1;
        end
      end

      ST_FETCH: begin
        if (i_s_tvalid && r_s_tready) begin
          w_state_nxt    = ST_SHIFT;
          w_s_tready_nxt = 1'b0;
          w_last_nxt     = i_s_tlast;
          w_div_nxt      = '0;
          w_edge_nxt     = '0;
          w_rx_nxt       = '0;
          // CPHA=0 needs the first bit on the wire before the first edge;
          // CPHA=1 drives it on the first (leading) edge instead.
          if (!CPHA) begin
            w_mosi_nxt = pick_bit(i_s_tdata, MSBF);
            w_tx_nxt   = advance(i_s_tdata, MSBF);
          end else begin
            w_tx_nxt   = i_s_tdata;
          end
        end
      end

      ST_SHIFT: begin
        if (w_hit) begin
          w_div_nxt  = '0;
          w_sclk_nxt = ~r_sclk;
          w_edge_nxt = r_edge + 4'd1;
          if (w_sample) begin
            w_rx_nxt = w_rx_shift;
          end else begin
            w_mosi_nxt = pick_bit(r_tx, MSBF);
            w_tx_nxt   = advance(r_tx, MSBF);
          end
          // 16th edge returns sclk to idle; the byte is complete here for both
          // phases (CPHA=1 takes its 8th sample on this same edge).
          if (r_edge == 4'd15) begin
            w_state_nxt    = ST_PUSH;
            w_m_tdata_nxt  = w_sample ? w_rx_shift : r_rx;
            w_m_tlast_nxt  = r_last;
            w_m_tvalid_nxt = 1'b1;
          end
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end

      ST_PUSH: begin
        if (i_m_tready) begin
          w_m_tvalid_nxt = 1'b0;
          w_num_nxt      = (r_num == '1) ? r_num : r_num + 32'd1;
          if (r_last) begin
            w_state_nxt = ST_DONE;
            w_div_nxt   = '0;
          end else begin
            w_state_nxt    = ST_FETCH;
            w_s_tready_nxt = 1'b1;
          end
        end
      end

      ST_DONE: begin
        if (w_hit) begin
          w_state_nxt = ST_IDLE;
          w_div_nxt   = '0;
          w_cs_nxt    = 1'b1;
          w_busy_nxt  = 1'b0;
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst == RSTL) begin
      r_state    <= ST_IDLE;
      r_div      <= '0;
      r_edge     <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_last     <= 1'b0;
      r_sclk     <= CPOL;
      r_mosi     <= 1'b0;
      r_cs       <= 1'b1;
      r_s_tready <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_num      <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_div      <= w_div_nxt;
      r_edge     <= w_edge_nxt;
      r_tx       <= w_tx_nxt;
      r_rx       <= w_rx_nxt;
      r_last     <= w_last_nxt;
      r_sclk     <= w_sclk_nxt;
      r_mosi     <= w_mosi_nxt;
      r_cs       <= w_cs_nxt;
      r_s_tready <= w_s_tready_nxt;
      r_m_tdata  <= w_m_tdata_nxt;
      r_m_tvalid <= w_m_tvalid_nxt;
      r_m_tlast  <= w_m_tlast_nxt;
      r_num      <= w_num_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign o_sclk      = r_sclk;
  assign o_mosi      = r_mosi;
  assign o_cs        = r_cs;
  assign o_s_tready  = r_s_tready;
  assign o_m_tdata   = r_m_tdata;
  assign o_m_tvalid  = r_m_tvalid;
  assign o_m_tlast   = r_m_tlast;
  assign o_num_bytes = r_num;
  assign o_busy      = r_busy;

endmodule

// File: rtl/spi_master_wrapper.sv
// Drop-in top for the SPI master: maps the legacy port/parameter names onto
// the spi_master core. No logic lives here.
// Ports:
//   clk_in, rst_in           clock; synchronous reset (asserted at RST_LEVEL_G)
//   sclk, mosi, miso, cs     SPI bus (cs active-low)
//   s_axis_*                 TX byte stream
//   m_axis_*                 RX byte stream
//   trigger                  start request
//   num_bytes                bytes completed in current/last transaction
//   busy                     high from start until cs released
module spi_master_wrapper
  import spi_master_pkg::*;
#(
  parameter int unsigned CLOCK_POLARITY_G = 0,
  parameter int unsigned CLOCK_PHASE_G    = 0,
  parameter int unsigned MSB_FIRST_G      = 1,
  parameter int unsigned RST_LEVEL_G      = 0,
  parameter int unsigned SCLK_HALF_G      = 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs,
  input  logic [BYTE_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [BYTE_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  input  logic              trigger,
  output logic [31:0]       num_bytes,
  output logic              busy
);

  spi_master #(
    .CLOCK_POLARITY_G (CLOCK_POLARITY_G),
    .CLOCK_PHASE_G    (CLOCK_PHASE_G),
    .MSB_FIRST_G      (MSB_FIRST_G),
    .RST_LEVEL_G      (RST_LEVEL_G),
    .SCLK_HALF_G      (SCLK_HALF_G)
  ) u_spi_master (
    .i_clk       (clk_in),
    .i_rst       (rst_in),
    .o_sclk      (sclk),
    .o_mosi      (mosi),
    .i_miso      (miso),
    .o_cs        (cs),
    .i_s_tdata   (s_axis_tdata),
    .i_s_tvalid  (s_axis_tvalid),
    .o_s_tready  (s_axis_tready),
    .i_s_tlast   (s_axis_tlast),
    .o_m_tdata   (m_axis_tdata),
    .o_m_tvalid  (m_axis_tvalid),
    .i_m_tready  (m_axis_tready),
    .o_m_tlast   (m_axis_tlast),
    .i_trigger   (trigger),
    .o_num_bytes (num_bytes),
    .o_busy      (busy)
  );

endmodule

// File: tb/tb_spi_master_wrapper.sv
// Bench for spi_master_wrapper. Five instances cover CPOL/CPHA 00,10,01,11
// (MSB first) and an LSB-first instance; one instance is active at a time.
// A behavioural SPI slave and an RX monitor check against scoreboard queues.
module tb_spi_master_wrapper;

  localparam int NI = 5;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic          clk_in;
  logic          rst_in;
  logic [NI-1:0] sclk, mosi, miso, cs;
  logic [NI-1:0] s_tvalid, s_tready, s_tlast;
  logic [NI-1:0] m_tvalid, m_tready, m_tlast;
  logic [NI-1:0] trigger, busy;
  logic [7:0]    s_tdata   [NI];
  logic [7:0]    m_tdata   [NI];
  logic [31:0]   num_bytes [NI];

  int sel;
  int n_checks = 0;
  int n_errors = 0;

  beat_t      tx_q[$];
  beat_t      exp_rx_q[$];
  logic [7:0] exp_mosi_q[$];
  logic [7:0] slave_q[$];

  logic [7:0]  sl_out, sl_in, sl_seq, last_seq;
  int unsigned sl_out_n, sl_in_n;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    spi_master_wrapper #(
      .CLOCK_POLARITY_G (g % 2),
      .CLOCK_PHASE_G    ((g / 2) % 2),
      .MSB_FIRST_G      ((g == 4) ? 0 : 1),
      .RST_LEVEL_G      (0),
      .SCLK_HALF_G      ((g == 3) ? 3 : 1)
    ) u_dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .sclk          (sclk[g]),
      .mosi          (mosi[g]),
      .miso          (miso[g]),
      .cs            (cs[g]),
      .s_axis_tdata  (s_tdata[g]),
      .s_axis_tvalid (s_tvalid[g]),
      .s_axis_tready (s_tready[g]),
      .s_axis_tlast  (s_tlast[g]),
      .m_axis_tdata  (m_tdata[g]),
      .m_axis_tvalid (m_tvalid[g]),
      .m_axis_tready (m_tready[g]),
      .m_axis_tlast  (m_tlast[g]),
      .trigger       (trigger[g]),
      .num_bytes     (num_bytes[g]),
      .busy          (busy[g])
    );
  end

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  function automatic logic cpol_of(input int i);
    return ((i % 2) != 0);
  endfunction

  function automatic logic cpha_of(input int i);
    return (((i / 2) % 2) != 0);
  endfunction

  function automatic logic msb_of(input int i);
    return (i != 4);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (inst %0d, t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  task automatic push_byte(input logic [7:0] tx, input logic [7:0] rx, input logic last);
    tx_q.push_back({tx, last});
    exp_mosi_q.push_back(tx);
    slave_q.push_back(rx);
    exp_rx_q.push_back({rx, last});
  endtask

  task automatic push_std();
    push_byte(8'h37, 8'hC8, 1'b0);
    push_byte(8'h48, 8'hB7, 1'b0);
    push_byte(8'h59, 8'hA6, 1'b1);
  endtask

  task automatic pulse_trigger(input int i);
    @(posedge clk_in); #1 trigger[i] = 1'b1;
    @(posedge clk_in); #1 trigger[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    int unsigned n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while ((busy[i] || !cs[i]) && n < 1000);
    check_eq("done_busy", 32'(busy[i]), 32'd0);
    check_eq("done_cs", 32'(cs[i]), 32'd1);
  endtask

  task automatic sl_load();
    if (slave_q.size() > 0) sl_out = slave_q.pop_front();
    else sl_out = 8'hFF;
    sl_out_n = 0;
  endtask

  task automatic sl_emit(input int i);
    if (msb_of(i)) begin
      miso[i] = sl_out[7];
      sl_out  = {sl_out[6:0], 1'b0};
    end else begin
      miso[i] = sl_out[0];
      sl_out  = {1'b0, sl_out[7:1]};
    end
    sl_out_n++;
  endtask

  // TX feeder: presents the head of tx_q on the active instance.
  initial begin : feeder
    logic hs;
    s_tvalid = '0;
    s_tlast  = '0;
    for (int i = 0; i < NI; i++) s_tdata[i] = '0;
    forever begin
      @(negedge clk_in);
      hs = s_tvalid[sel] && s_tready[sel];
      @(posedge clk_in); #1;
      if (hs && tx_q.size() > 0) void'(tx_q.pop_front());
      if (tx_q.size() > 0) begin
        s_tvalid[sel] = 1'b1;
        s_tdata[sel]  = tx_q[0].d;
        s_tlast[sel]  = tx_q[0].l;
      end else begin
        s_tvalid[sel] = 1'b0;
      end
    end
  end

  // SPI slave model for the active instance, evaluated between clock edges.
  initial begin : slave
    logic [NI-1:0] prev_sclk, prev_cs;
    logic lead, trail, samp, shft;
    int i;
    miso = '0;
    sl_out = '0; sl_in = '0; sl_seq = '0; last_seq = '0;
    sl_out_n = 8; sl_in_n = 0;
    prev_sclk = '0;
    prev_cs = '1;
    forever begin
      @(negedge clk_in);
      i = sel;
      if (cs[i]) begin
        sl_out_n = 8;
        sl_in_n  = 0;
      end else begin
        lead  = (sclk[i] != prev_sclk[i]) && (sclk[i] != cpol_of(i));
        trail = (sclk[i] != prev_sclk[i]) && (sclk[i] == cpol_of(i));
        samp  = cpha_of(i) ? trail : lead;
        shft  = cpha_of(i) ? lead : trail;
        if (prev_cs[i] && !cpha_of(i)) begin
          sl_load();
          sl_emit(i);
        end
        if (shft) begin
          if (sl_out_n == 8) sl_load();
          sl_emit(i);
        end
        if (samp) begin
          sl_in  = msb_of(i) ? {sl_in[6:0], mosi[i]} : {mosi[i], sl_in[7:1]};
          sl_seq = {sl_seq[6:0], mosi[i]};
          sl_in_n++;
          if (sl_in_n == 8) begin
            sl_in_n  = 0;
            last_seq = sl_seq;
            if (exp_mosi_q.size() > 0) check_eq("mosi_byte", 32'(sl_in), 32'(exp_mosi_q.pop_front()));
            else check_eq("mosi_extra", 32'(exp_mosi_q.size()), 32'd1);
          end
        end
      end
      prev_sclk = sclk;
      prev_cs   = cs;
    end
  end

  // RX monitor: each handshake pops one expected beat.
  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clk_in);
      if (m_tvalid[sel] && m_tready[sel]) begin
        if (exp_rx_q.size() > 0) begin
          e = exp_rx_q.pop_front();
          check_eq("rx_data", 32'(m_tdata[sel]), 32'(e.d));
          check_eq("rx_last", 32'(m_tlast[sel]), 32'(e.l));
        end else begin
          check_eq("rx_extra", 32'(exp_rx_q.size()), 32'd1);
        end
      end
    end
  end

  task automatic run_std(input int i);
    sel = i;
    m_tready = '0;
    m_tready[i] = 1'b1;
    push_std();
    repeat (4) @(negedge clk_in);
    check_eq("tready_idle", 32'(s_tready[i]), 32'd0);
    check_eq("sclk_idle_before", 32'(sclk[i]), 32'(cpol_of(i)));
    pulse_trigger(i);
    check_eq("start_busy", 32'(busy[i]), 32'd1);
    check_eq("start_cs", 32'(cs[i]), 32'd0);
    check_eq("start_nbytes", num_bytes[i], 32'd0);
    wait_done(i);
    check_eq("nbytes", num_bytes[i], 32'd3);
    check_eq("sclk_idle_after", 32'(sclk[i]), 32'(cpol_of(i)));
    check_eq("rx_pending", 32'(exp_rx_q.size()), 32'd0);
    check_eq("mosi_pending", 32'(exp_mosi_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int unsigned n;
    rst_in   = 1'b0;
    trigger  = '0;
    m_tready = '0;
    sel      = 0;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b1;
    @(negedge clk_in);
    check_eq("rst_sclk", 32'(sclk[0]), 32'd0);
    check_eq("rst_sclk_cpol1", 32'(sclk[1]), 32'd1);
    check_eq("rst_cs", 32'(cs[0]), 32'd1);
    check_eq("rst_mosi", 32'(mosi[0]), 32'd0);
    check_eq("rst_tready", 32'(s_tready[0]), 32'd0);
    check_eq("rst_mvalid", 32'(m_tvalid[0]), 32'd0);
    check_eq("rst_mdata", 32'(m_tdata[0]), 32'd0);
    check_eq("rst_mlast", 32'(m_tlast[0]), 32'd0);
    check_eq("rst_busy", 32'(busy[0]), 32'd0);
    check_eq("rst_nbytes", num_bytes[0], 32'd0);

    // All four clock modes, identical data.
    for (int i = 0; i < 4; i++) run_std(i);

    // LSB first: 0x01 goes out as 1 followed by seven 0s.
    sel = 4;
    m_tready = '0;
    m_tready[4] = 1'b1;
    push_byte(8'h01, 8'h5A, 1'b1);
    repeat (3) @(negedge clk_in);
    pulse_trigger(4);
    wait_done(4);
    check_eq("lsb_seq", 32'(last_seq), 32'h80);
    check_eq("lsb_nbytes", num_bytes[4], 32'd1);

    // RX backpressure on the default instance.
    sel = 0;
    m_tready = '0;
    push_std();
    repeat (3) @(negedge clk_in);
    pulse_trigger(0);
    n = 0;
    while (!m_tvalid[0] && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    check_eq("stall_valid_seen", 32'(m_tvalid[0]), 32'd1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_in);
      check_eq("stall_sclk", 32'(sclk[0]), 32'd0);
      check_eq("stall_cs", 32'(cs[0]), 32'd0);
      check_eq("stall_data", 32'(m_tdata[0]), 32'hC8);
    end
    @(posedge clk_in); #1 m_tready[0] = 1'b1;
    wait_done(0);
    check_eq("stall_nbytes", num_bytes[0], 32'd3);
    check_eq("stall_rx_pending", 32'(exp_rx_q.size()), 32'd0);

    // Trigger while busy is ignored.
    push_std();
    repeat (3) @(negedge clk_in);
    pulse_trigger(0);
    repeat (10) @(negedge clk_in);
    pulse_trigger(0);
    wait_done(0);
    check_eq("retrig_nbytes", num_bytes[0], 32'd3);
    repeat (30) @(negedge clk_in);
    check_eq("retrig_busy", 32'(busy[0]), 32'd0);
    check_eq("retrig_cs", 32'(cs[0]), 32'd1);
    check_eq("retrig_nbytes_late", num_bytes[0], 32'd3);

    // Reset during the second byte, then a clean transaction.
    push_std();
    repeat (3) @(negedge clk_in);
    pulse_trigger(0);
    n = 0;
    while (exp_rx_q.size() > 2 && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    check_eq("abort_first_rx", 32'(exp_rx_q.size()), 32'd2);
    repeat (6) @(negedge clk_in);
    @(posedge clk_in); #1 rst_in = 1'b0;
    @(posedge clk_in); #1 rst_in = 1'b1;
    check_eq("abort_cs", 32'(cs[0]), 32'd1);
    check_eq("abort_busy", 32'(busy[0]), 32'd0);
    check_eq("abort_mvalid", 32'(m_tvalid[0]), 32'd0);
    check_eq("abort_nbytes", num_bytes[0], 32'd0);
    tx_q.delete();
    exp_rx_q.delete();
    exp_mosi_q.delete();
    slave_q.delete();
    repeat (5) @(negedge clk_in);
    check_eq("abort_no_push", 32'(m_tvalid[0]), 32'd0);
    push_std();
    repeat (3) @(negedge clk_in);
    pulse_trigger(0);
    wait_done(0);
    check_eq("post_abort_nbytes", num_bytes[0], 32'd3);
    check_eq("post_abort_rx_pending", 32'(exp_rx_q.size()), 32'd0);
    check_eq("post_abort_mosi_pending", 32'(exp_mosi_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
